instr_queue: RTL

Instruction queue between the fetch stage and decode in the 16-bit pipelined core. It buffers up to DEPTH fetched {instruction, PC+2} pairs with a valid/ready handshake on both sides, so decode stalls do not have to freeze the PC register combinationally. A one-cycle flush discards wrong-path instructions on a taken branch or jump. The queue stops accepting after a HALT is enqueued.

---
 rtl/instr_queue_pkg.sv | 23 ++
 rtl/iq_store.sv | 25 ++
 rtl/instr_queue.sv | 77 +++++++
 3 files changed

// File: rtl/instr_queue_pkg.sv
// Core-wide instruction constants shared by the fetch queue and decode.
// Holds the NOP word, HALT opcode, opcode field position and queue entry layout.
package instr_queue_pkg;

  localparam logic [15:0] NOP_INSTR   = 16'h0800;
  localparam logic [4:0]  HALT_OPCODE = 5'b00000;
  localparam int          OPC_MSB     = 15;
  localparam int          OPC_LSB     = 11;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc2;
  } iq_entry_t;

  function automatic logic [4:0] opcode(input logic [15:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic is_halt(input logic [15:0] instr);
    return opcode(instr) == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/iq_store.sv
// Entry storage for instr_queue: DEPTH x 32-bit registers, one write port, one
// combinational read port (0-cycle read). No reset on the array, no backpressure.
module iq_store #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_queue.sv
// Fetch-to-decode FWFT queue: 1-cycle enqueue-to-head latency, no bypass/pass-through.
// in_ready depends only on registered state (not full, no HALT pending); flush empties it.
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] NOP_INSTR = instr_queue_pkg::NOP_INSTR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [15:0]              in_instr,
  input  logic [15:0]              in_pc2,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [15:0]              out_instr,
  output logic [15:0]              out_pc2,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic                     halt_pending,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          enq;
  logic          deq;
  iq_entry_t     wr_entry;
  iq_entry_t     rd_entry;

  assign in_ready  = (count < CW'(DEPTH)) && !halt_pending;
  assign out_valid = (count != '0);
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;
  assign wr_entry  = '{instr: in_instr, pc2: in_pc2};

  // Stale entries are harmless after a flush, so the array is never cleared.
  iq_store #(.DEPTH(DEPTH)) u_store (
    .clk   (clk),
    .we    (enq && !flush && !rst),
    .waddr (tail),
    .wdata (wr_entry),
    .raddr (head),
    .rdata (rd_entry)
  );

  assign out_instr = out_valid ? rd_entry.instr : NOP_INSTR;
  assign out_pc2   = out_valid ? rd_entry.pc2   : 16'h0000;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      halt_pending <= 1'b0;
    end else begin
      if (enq) begin
        tail <= tail + 1'b1;
      end
      if (deq) begin
        head <= head + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (enq && is_halt(in_instr)) begin
        halt_pending <= 1'b1;
      end
    end
  end

endmodule
